// File: rtl/game_flow_if.sv
// -----------------------------------------------------------------------------
// game_flow_if
// Bundles the debounced button pulses coming into the game flow controller and
// the control/display values it drives out to the display, mole generator and
// score counter.
//   btn_left/right/up/down/center : single-cycle button pulses
//   gamestart, gameend, lr        : game phase and selected setup field
//   difficulty                    : 0 easy, 1 medium, 2 hard
//   time_tens, time_ones          : BCD digits of the displayed time
//   sec_tick, score_clr, mole_en  : per-second pulse, score clear, mole gate
// Modports: master = the controller, slave = the surrounding system.
// -----------------------------------------------------------------------------
interface game_flow_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_center;
  logic       gamestart;
  logic       gameend;
  logic       lr;
  logic [1:0] difficulty;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic       sec_tick;
  logic       score_clr;
  logic       mole_en;

  modport master (
    input  btn_left, btn_right, btn_up, btn_down, btn_center,
    output gamestart, gameend, lr, difficulty, time_tens, time_ones,
           sec_tick, score_clr, mole_en
  );

  modport slave (
    output btn_left, btn_right, btn_up, btn_down, btn_center,
    input  gamestart, gameend, lr, difficulty, time_tens, time_ones,
           sec_tick, score_clr, mole_en
  );
endinterface

// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
// Runs the whack-a-mole SETUP -> RUN -> END flow: setup menu (field select and
// adjust of difficulty / game length), the per-second countdown and the
// return to setup. Every output is registered.
//   CLK100MHZ : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : game_flow_if.master (buttons in, control and display out)
// -----------------------------------------------------------------------------
module game_flow_controller #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int TIME_DEFAULT  = 30,
  parameter int TIME_MIN      = 10,
  parameter int TIME_MAX      = 90,
  parameter int TIME_STEP     = 5
) (
  input  logic         CLK100MHZ,
  input  logic         rst_n,
  game_flow_if.master  bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] T_DEF  = 7'(TIME_DEFAULT);
  localparam logic [6:0] T_MIN  = 7'(TIME_MIN);
  localparam logic [6:0] T_MAX  = 7'(TIME_MAX);
  localparam logic [6:0] T_STEP = 7'(TIME_STEP);

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_RUN   = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t        state_r;
  logic [6:0]    set_time_r;
  logic [6:0]    remaining_r;
  logic [PW-1:0] prescaler_r;
  logic          lr_r;
  logic [1:0]    difficulty_r;
  logic          gamestart_r;
  logic          gameend_r;
  logic          sec_tick_r;
  logic          score_clr_r;
  logic          mole_en_r;
  logic [3:0]    time_tens_r;
  logic [3:0]    time_ones_r;
  logic [6:0]    disp_s;
  logic          up_s;
  logic          down_s;

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  // Value shown on the display: chosen length in setup, countdown otherwise.
  always_comb begin
    disp_s = set_time_r;
    if (state_r == ST_SETUP) begin
      disp_s = set_time_r;
    end else begin
      disp_s = remaining_r;
    end
  end

  // Simultaneous up+down cancels out, so decode each as exclusive.
  always_comb begin
    up_s   = bus.btn_up & ~bus.btn_down;
    down_s = bus.btn_down & ~bus.btn_up;
  end

  // Game flow state machine with all outputs registered.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SETUP;
      set_time_r   <= T_DEF;
      remaining_r  <= 7'd0;
      prescaler_r  <= '0;
      lr_r         <= 1'b0;
      difficulty_r <= 2'd0;
      gamestart_r  <= 1'b0;
      gameend_r    <= 1'b0;
      sec_tick_r   <= 1'b0;
      score_clr_r  <= 1'b0;
      mole_en_r    <= 1'b0;
      time_tens_r  <= bcd_tens(T_DEF);
      time_ones_r  <= bcd_ones(T_DEF);
    end else begin
      sec_tick_r  <= 1'b0;
      score_clr_r <= 1'b0;
      // Digits trail the internal value by one cycle.
      time_tens_r <= bcd_tens(disp_s);
      time_ones_r <= bcd_ones(disp_s);
      case (state_r)
        ST_SETUP: begin
          if (bus.btn_center) begin
            // Start wins over any other button in the same cycle.
            state_r     <= ST_RUN;
            remaining_r <= set_time_r;
            prescaler_r <= '0;
            score_clr_r <= 1'b1;
            gamestart_r <= 1'b1;
            gameend_r   <= 1'b0;
            mole_en_r   <= 1'b1;
          end else begin
            if (bus.btn_left && !bus.btn_right) begin
              lr_r <= 1'b0;
            end else if (bus.btn_right && !bus.btn_left) begin
              lr_r <= 1'b1;
            end
            // Saturation tests happen before the add/subtract, so no wrap.
            if (up_s) begin
              if (!lr_r) begin
                difficulty_r <= (difficulty_r >= 2'd2) ? 2'd2 : difficulty_r + 2'd1;
              end else begin
                set_time_r <= (set_time_r >= T_MAX - T_STEP) ? T_MAX : set_time_r + T_STEP;
              end
            end else if (down_s) begin
              if (!lr_r) begin
                difficulty_r <= (difficulty_r == 2'd0) ? 2'd0 : difficulty_r - 2'd1;
              end else begin
                set_time_r <= (set_time_r <= T_MIN + T_STEP) ? T_MIN : set_time_r - T_STEP;
              end
            end
          end
        end
        ST_RUN: begin
          if (prescaler_r == PS_LAST) begin
            prescaler_r <= '0;
            sec_tick_r  <= 1'b1;
            if (remaining_r <= 7'd1) begin
              remaining_r <= 7'd0;
              state_r     <= ST_END;
              gameend_r   <= 1'b1;
              mole_en_r   <= 1'b0;
            end else begin
              remaining_r <= remaining_r - 7'd1;
            end
          end else begin
            prescaler_r <= prescaler_r + PW'(1);
          end
        end
        ST_END: begin
          prescaler_r <= '0;
          if (bus.btn_center) begin
            state_r     <= ST_SETUP;
            gamestart_r <= 1'b0;
            gameend_r   <= 1'b0;
            mole_en_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_SETUP;
          prescaler_r <= '0;
          gamestart_r <= 1'b0;
          gameend_r   <= 1'b0;
          mole_en_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gamestart  = gamestart_r;
  assign bus.gameend    = gameend_r;
  assign bus.lr         = lr_r;
  assign bus.difficulty = difficulty_r;
  assign bus.time_tens  = time_tens_r;
  assign bus.time_ones  = time_ones_r;
  assign bus.sec_tick   = sec_tick_r;
  assign bus.score_clr  = score_clr_r;
  assign bus.mole_en    = mole_en_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_game_flow_controller
// Directed bench for game_flow_controller with a 4-cycle game second.
// Inputs change on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_game_flow_controller;

  logic CLK100MHZ;
  logic rst_n;
  int   checks_total;
  int   checks_passed;

  game_flow_if bus ();

  game_flow_controller #(
    .TICKS_PER_SEC (4),
    .TIME_DEFAULT  (30),
    .TIME_MIN      (10),
    .TIME_MAX      (90),
    .TIME_STEP     (5)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Drive one button pattern for exactly one rising edge (negedge to negedge).
  task automatic pulse(input logic l, input logic r, input logic u,
                       input logic d, input logic c);
    bus.btn_left   = l;
    bus.btn_right  = r;
    bus.btn_up     = u;
    bus.btn_down   = d;
    bus.btn_center = c;
    @(negedge CLK100MHZ);
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_center = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks_total++;
    if (bus.time_tens !== 4'd3 || bus.time_ones !== 4'd0 || bus.gamestart !== 1'b0) begin
      $display("FAIL reset_hold: tens=%0d ones=%0d gs=%b, want 3 0 0",
               bus.time_tens, bus.time_ones, bus.gamestart);
    end else checks_passed++;
    @(negedge CLK100MHZ);
    rst_n = 1'b1;
    @(negedge CLK100MHZ);
    checks_total++;
    if ({bus.gamestart, bus.gameend, bus.lr, bus.difficulty, bus.time_tens, bus.time_ones,
         bus.sec_tick, bus.score_clr, bus.mole_en} !== {1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0,
         1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_release: gs=%b ge=%b lr=%b diff=%0d t=%0d%0d tick=%b clr=%b mole=%b",
               bus.gamestart, bus.gameend, bus.lr, bus.difficulty, bus.time_tens,
               bus.time_ones, bus.sec_tick, bus.score_clr, bus.mole_en);
    end else checks_passed++;
  endtask

  task automatic test_difficulty();
    logic [1:0] exp_up [3];
    logic [1:0] exp_dn [3];
    exp_up = '{2'd1, 2'd2, 2'd2};
    exp_dn = '{2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks_total++;
      if (bus.difficulty !== exp_up[i]) begin
        $display("FAIL diff_up%0d: got %0d want %0d", i, bus.difficulty, exp_up[i]);
      end else checks_passed++;
    end
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks_total++;
      if (bus.difficulty !== exp_dn[i]) begin
        $display("FAIL diff_dn%0d: got %0d want %0d", i, bus.difficulty, exp_dn[i]);
      end else checks_passed++;
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks_total++;
    if (bus.difficulty !== 2'd1) begin
      $display("FAIL diff_updown: got %0d want 1", bus.difficulty);
    end else checks_passed++;
  endtask

  task automatic test_time_select();
    int         val;
    logic [3:0] et;
    logic [3:0] eo;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks_total++;
    if (bus.lr !== 1'b1) begin
      $display("FAIL lr_right: got %b want 1", bus.lr);
    end else checks_passed++;
    for (int i = 1; i <= 14; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK100MHZ);
      val = (30 + 5 * i > 90) ? 90 : 30 + 5 * i;
      et = 4'(val / 10);
      eo = 4'(val % 10);
      checks_total++;
      if (bus.time_tens !== et || bus.time_ones !== eo) begin
        $display("FAIL time_up%0d: got %0d%0d want %0d%0d", i, bus.time_tens, bus.time_ones, et, eo);
      end else checks_passed++;
    end
    for (int i = 1; i <= 17; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge CLK100MHZ);
      val = (90 - 5 * i < 10) ? 10 : 90 - 5 * i;
      et = 4'(val / 10);
      eo = 4'(val % 10);
      checks_total++;
      if (bus.time_tens !== et || bus.time_ones !== eo) begin
        $display("FAIL time_dn%0d: got %0d%0d want %0d%0d", i, bus.time_tens, bus.time_ones, et, eo);
      end else checks_passed++;
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks_total++;
    if (bus.lr !== 1'b1 || bus.difficulty !== 2'd1) begin
      $display("FAIL lr_both: lr=%b diff=%0d want 1 1", bus.lr, bus.difficulty);
    end else checks_passed++;
  endtask

  task automatic test_run();
    int         k;
    int         val;
    logic       exp_tick;
    logic [3:0] et;
    logic [3:0] eo;
    // Up pressed together with center must be ignored (set_time stays 10).
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks_total++;
    if (bus.score_clr !== 1'b1 || bus.gamestart !== 1'b1 || bus.mole_en !== 1'b1 ||
        bus.gameend !== 1'b0) begin
      $display("FAIL run_entry: clr=%b gs=%b mole=%b ge=%b want 1 1 1 0",
               bus.score_clr, bus.gamestart, bus.mole_en, bus.gameend);
    end else checks_passed++;
    // Negedge n follows the n-th rising edge counted from the start press.
    for (int n = 2; n <= 46; n++) begin
      @(negedge CLK100MHZ);
      bus.btn_up     = (n == 10);
      bus.btn_left   = (n == 10);
      bus.btn_center = (n == 10);
      exp_tick = ((n - 1) % 4 == 0) && (n <= 41);
      checks_total++;
      if (bus.sec_tick !== exp_tick || bus.score_clr !== 1'b0 ||
          bus.gameend !== (n >= 41) || bus.mole_en !== (n < 41) || bus.gamestart !== 1'b1) begin
        $display("FAIL run_cyc%0d: tick=%b clr=%b ge=%b mole=%b gs=%b want tick=%b clr=0 ge=%b mole=%b gs=1",
                 n, bus.sec_tick, bus.score_clr, bus.gameend, bus.mole_en, bus.gamestart,
                 exp_tick, (n >= 41), (n < 41));
      end else checks_passed++;
      if ((n - 2) % 4 == 0) begin
        k   = (n - 2) / 4;
        val = (k <= 10) ? 10 - k : 0;
        et  = 4'(val / 10);
        eo  = 4'(val % 10);
        checks_total++;
        if (bus.time_tens !== et || bus.time_ones !== eo) begin
          $display("FAIL run_digits%0d: got %0d%0d want %0d%0d", n, bus.time_tens, bus.time_ones, et, eo);
        end else checks_passed++;
      end
    end
    checks_total++;
    if (bus.difficulty !== 2'd1 || bus.lr !== 1'b1) begin
      $display("FAIL run_frozen: diff=%0d lr=%b want 1 1", bus.difficulty, bus.lr);
    end else checks_passed++;
  endtask

  task automatic test_end_return();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks_total++;
    if (bus.gamestart !== 1'b0 || bus.gameend !== 1'b0 || bus.mole_en !== 1'b0) begin
      $display("FAIL end_return: gs=%b ge=%b mole=%b want 0 0 0", bus.gamestart, bus.gameend, bus.mole_en);
    end else checks_passed++;
    @(negedge CLK100MHZ);
    checks_total++;
    if (bus.time_tens !== 4'd1 || bus.time_ones !== 4'd0 || bus.difficulty !== 2'd1 ||
        bus.lr !== 1'b1) begin
      $display("FAIL end_retain: t=%0d%0d diff=%0d lr=%b want 10 1 1",
               bus.time_tens, bus.time_ones, bus.difficulty, bus.lr);
    end else checks_passed++;
  endtask

  task automatic test_reset_mid_run();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Four ticks after start: remaining is 6.
    for (int n = 2; n <= 18; n++) @(negedge CLK100MHZ);
    checks_total++;
    if (bus.time_tens !== 4'd0 || bus.time_ones !== 4'd6) begin
      $display("FAIL mid_run_pre: t=%0d%0d want 06", bus.time_tens, bus.time_ones);
    end else checks_passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if ({bus.gamestart, bus.gameend, bus.lr, bus.difficulty, bus.time_tens, bus.time_ones,
         bus.sec_tick, bus.score_clr, bus.mole_en} !== {1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0,
         1'b0, 1'b0, 1'b0}) begin
      $display("FAIL mid_run_async: gs=%b ge=%b lr=%b diff=%0d t=%0d%0d tick=%b clr=%b mole=%b",
               bus.gamestart, bus.gameend, bus.lr, bus.difficulty, bus.time_tens,
               bus.time_ones, bus.sec_tick, bus.score_clr, bus.mole_en);
    end else checks_passed++;
    @(negedge CLK100MHZ);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK100MHZ);
      checks_total++;
      if (bus.sec_tick !== 1'b0 || bus.score_clr !== 1'b0 || bus.gamestart !== 1'b0 ||
          bus.time_tens !== 4'd3 || bus.time_ones !== 4'd0) begin
        $display("FAIL post_reset%0d: tick=%b clr=%b gs=%b t=%0d%0d want 0 0 0 30",
                 n, bus.sec_tick, bus.score_clr, bus.gamestart, bus.time_tens, bus.time_ones);
      end else checks_passed++;
    end
  endtask

  initial begin
    checks_total   = 0;
    checks_passed  = 0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_center = 1'b0;
    test_reset();
    test_difficulty();
    test_time_select();
    test_run();
    test_end_return();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Sequences the whack-a-mole game and supplies the control and value inputs to the seven-segment display driver: gamestart, gameend, lr, difficulty selection and the BCD game timer. It runs the SETUP → RUN → END flow, handles the setup menu (field select, adjust) and the 1 Hz countdown. Its outputs also gate the mole generator and clear the score counter. Buttons arrive as debounced, single-cycle pulses from the input conditioning block.

Parameters:
TICKS_PER_SEC, 100000000, clock cycles per game second (benches use 4)
TIME_DEFAULT, 30, game length in seconds after reset
TIME_MIN, 10, lowest selectable game length (s)
TIME_MAX, 90, highest selectable game length (s), must be ≤ 99
TIME_STEP, 5, seconds added or removed per up/down press

Ports:
CLK100MHZ  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_left  input  1  pulse: select difficulty field
btn_right  input  1  pulse: select time field
btn_up  input  1  pulse: increment selected field
btn_down  input  1  pulse: decrement selected field
btn_center  input  1  pulse: start game / return to setup
gamestart  output  1  0 in SETUP, 1 in RUN and END
gameend  output  1  1 only in END
lr  output  1  selected setup field: 0 = difficulty, 1 = time
difficulty  output  2  0 = easy, 1 = medium, 2 = hard
time_tens  output  4  BCD tens digit of the displayed time
time_ones  output  4  BCD ones digit of the displayed time
sec_tick  output  1  one-cycle pulse per game second in RUN
score_clr  output  1  one-cycle pulse on entry to RUN
mole_en  output  1  1 only in RUN

Behaviour:
- Reset (async, rst_n=0):
  - state = SETUP
  - gamestart, gameend, lr, sec_tick, score_clr, mole_en = 0
  - difficulty = 0
  - set_time = TIME_DEFAULT, time_tens = 3, time_ones = 0 with defaults
  - prescaler = 0, remaining = 0
- All outputs are registered. Time digits update one cycle after the internal value changes. Digits are always the BCD of the displayed value: set_time in SETUP, remaining in RUN and END.
- SETUP:
  - btn_left sets lr=0; btn_right sets lr=1. Both in the same cycle: lr unchanged.
  - btn_up with lr=0: difficulty+1, saturating at 2. With lr=1: set_time+TIME_STEP, saturating at TIME_MAX.
  - btn_down with lr=0: difficulty-1, saturating at 0. With lr=1: set_time-TIME_STEP, saturating at TIME_MIN.
  - btn_up and btn_down in the same cycle: both ignored.
  - btn_center goes to RUN next cycle: remaining = set_time, prescaler = 0, score_clr = 1 for exactly one cycle, gamestart = 1, mole_en = 1.
  - btn_center takes priority over any other button pressed in the same cycle; those are ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap, sec_tick = 1 for one cycle and remaining decrements.
  - The tick that moves remaining from 1 to 0 also moves state to END: gameend = 1, mole_en = 0.
  - All buttons, including btn_center, are ignored. difficulty, lr and set_time are frozen.
- END:
  - Display shows 00. gamestart = 1, gameend = 1, prescaler held at 0, no sec_tick.
  - btn_center returns to SETUP: gamestart = 0, gameend = 0, digits show set_time again.
  - difficulty, lr and set_time are retained across games; they are not reset.
- Reset asserted mid-RUN or mid-END returns immediately to the reset values above. No partial tick or score_clr pulse is emitted after release.
- Arithmetic:
  - set_time and remaining are held as 7-bit binary.
  - BCD is computed as tens = value/10, ones = value%10, valid for 0..99.
  - Saturation compares before the add/subtract, so no wrap-around is possible.

Test Plan:
1. Reset, then release → gamestart=0, gameend=0, lr=0, difficulty=0, time_tens=3, time_ones=0.
2. SETUP, lr=0: btn_up ×3 → difficulty 1, 2, 2 (saturates). btn_down ×3 → 1, 0, 0. btn_up and btn_down together → no change.
3. btn_right, then btn_up ×14 → time goes 35, 40 … 90 and stays at 90 (digits 9,0). btn_down ×17 → stays at 10 (digits 1,0). btn_left and btn_right together → lr unchanged.
4. TICKS_PER_SEC=4, set_time=10, btn_center:
   - score_clr high for exactly one cycle; gamestart=1 and mole_en=1 the next cycle.
   - sec_tick every 4 cycles; digits go 1,0 → 0,9 → … → 0,0.
   - gameend=1 and mole_en=0 on the 10th tick; buttons pressed during RUN have no effect.
5. In END, btn_center → gamestart=0, gameend=0, digits return to 1,0, difficulty and lr keep their pre-game values.
6. rst_n pulsed low mid-RUN at remaining=6 → all outputs return to reset values asynchronously, set_time returns to 30, no sec_tick after release.
